// File: rtl/lcd_spi3w_pkg.sv
// Shared constants, state encoding and frame-field helpers for the LCD 3-wire serial slave.
package lcd_spi3w_pkg;

  localparam int FRAME_BITS    = 16;
  localparam int ADDR_BITS_CNT = 8;
  localparam int POS_A6        = 15;
  localparam int POS_RW        = 14;

  localparam logic [6:0] REG_BACKLIGHT = 7'h05;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_e;

  // Address bits sit at A6 and A5..A0 around the RW bit of the header byte.
  function automatic logic [6:0] frame_addr(input logic [15:0] frame);
    return {frame[POS_A6], frame[POS_RW-1:ADDR_BITS_CNT]};
  endfunction

  function automatic logic addr_in_range(input logic [6:0] addr, input int unsigned num_regs);
    return ({25'd0, addr} < num_regs);
  endfunction

endpackage

// File: rtl/lcd_spi3w_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
module lcd_spi3w_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus one extra flop holding the previous synchronized level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{IDLE_LVL}};
      prev_q <= IDLE_LVL;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(d_i);
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/lcd_spi3w_slave.sv
// LCD 3-wire serial command slave: oversamples SPENB/SPCLK/SPDA in sys_clk, decodes
// 16-bit frames, commits writes into an inline register file and returns read data.
module lcd_spi3w_slave
  import lcd_spi3w_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         NUM_REGS    = 16,
  parameter logic [7:0] REG_RESET   = 8'h00
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       spclk,
  input  logic       spenb,
  input  logic       spda_in,
  output logic       spda_out,
  output logic       spda_oe,
  output logic       cmd_valid,
  output logic       cmd_rw,
  output logic [6:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic       frame_err,
  output logic       overrun,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int          IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0]  ARM_CNT = 4'(SYNC_STAGES + 1);

  logic spclk_rise_s, spclk_fall_s;
  logic spenb_s, spenb_rise_s, spenb_fall_s;
  logic spda_s;
  logic clk_rise_s, clk_fall_s;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d, cnt_inc_s;
  logic [15:0] shift_q, shift_d, shift_nxt_s;
  logic        rw_q, rw_d;
  logic [7:0]  rdbuf_q, rdbuf_d;
  logic [7:0]  rdval_q, rdval_d;
  logic        oe_q, oe_d;
  logic        out_q, out_d;
  logic        valid_q, valid_d;
  logic        crw_q, crw_d;
  logic [6:0]  caddr_q, caddr_d;
  logic [7:0]  cdata_q, cdata_d;
  logic        ferr_q, ferr_d;
  logic        ovr_q, ovr_d;
  logic [3:0]  arm_q, arm_d;
  logic        armed_s;

  logic [7:0]  regs_q [NUM_REGS];
  logic        we_s;
  logic [6:0]  waddr_s;
  logic [7:0]  wdata_s;
  logic [6:0]  hdr_addr_s;
  logic [7:0]  hdr_data_s;
  logic [6:0]  frm_addr_s;

  lcd_spi3w_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_spclk (
    .clk_i (sys_clk),
    .rst_i (rst),
    .d_i   (spclk),
    .q_o   (),
    .rise_o(spclk_rise_s),
    .fall_o(spclk_fall_s)
  );

  lcd_spi3w_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_spenb (
    .clk_i (sys_clk),
    .rst_i (rst),
    .d_i   (spenb),
    .q_o   (spenb_s),
    .rise_o(spenb_rise_s),
    .fall_o(spenb_fall_s)
  );

  lcd_spi3w_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_spda (
    .clk_i (sys_clk),
    .rst_i (rst),
    .d_i   (spda_in),
    .q_o   (spda_s),
    .rise_o(),
    .fall_o()
  );

  assign clk_rise_s  = spclk_rise_s & ~spenb_s;
  assign clk_fall_s  = spclk_fall_s & ~spenb_s;
  assign cnt_inc_s   = cnt_q + 5'd1;
  assign shift_nxt_s = {shift_q[FRAME_BITS-2:0], spda_s};

  // Until the reset-loaded idle levels have flushed through the synchronizers, a low
  // spenb left over from an interrupted frame must not look like a fresh frame start.
  assign armed_s = (arm_q >= ARM_CNT);
  assign arm_d   = armed_s ? arm_q : (arm_q + 4'd1);

  assign hdr_addr_s = frame_addr({shift_nxt_s[7:0], 8'h00});
  assign hdr_data_s = addr_in_range(hdr_addr_s, NUM_REGS) ? regs_q[hdr_addr_s[IDX_W-1:0]] : 8'h00;
  assign frm_addr_s = frame_addr(shift_q);
  assign rd_data    = addr_in_range(rd_addr, NUM_REGS) ? regs_q[rd_addr[IDX_W-1:0]] : 8'h00;

  // Next-state, frame decode and commit logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rw_d    = rw_q;
    rdbuf_d = rdbuf_q;
    rdval_d = rdval_q;
    oe_d    = oe_q;
    out_d   = out_q;
    valid_d = 1'b0;
    crw_d   = crw_q;
    caddr_d = caddr_q;
    cdata_d = cdata_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    we_s    = 1'b0;
    waddr_s = frm_addr_s;
    wdata_s = shift_q[7:0];

    case (state_q)
      IDLE: begin
        if (spenb_fall_s && armed_s) begin
          cnt_d   = 5'd0;
          shift_d = 16'h0000;
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end

      ADDR, DATA: begin
        if (spenb_rise_s) begin
          ferr_d  = 1'b1;
          oe_d    = 1'b0;
          out_d   = 1'b0;
          state_d = IDLE;
        end else if (clk_rise_s) begin
          shift_d = shift_nxt_s;
          cnt_d   = cnt_inc_s;
          if (state_q == ADDR && cnt_inc_s == 5'(ADDR_BITS_CNT)) begin
            rw_d    = shift_nxt_s[POS_RW-ADDR_BITS_CNT];
            rdbuf_d = hdr_data_s;
            rdval_d = hdr_data_s;
            state_d = DATA;
          end else if (state_q == DATA && cnt_inc_s == 5'(FRAME_BITS)) begin
            state_d = DONE;
          end else begin
            state_d = state_q;
          end
        end else if (state_q == DATA && clk_fall_s && rw_q) begin
          // Read data leaves MSB first, one bit per falling edge
          oe_d    = 1'b1;
          out_d   = rdbuf_q[7];
          rdbuf_d = {rdbuf_q[6:0], 1'b0};
        end else begin
          state_d = state_q;
        end
      end

      DONE: begin
        if (spenb_rise_s) begin
          valid_d = 1'b1;
          caddr_d = frm_addr_s;
          crw_d   = shift_q[POS_RW];
          cdata_d = shift_q[POS_RW] ? rdval_q : shift_q[7:0];
          we_s    = ~shift_q[POS_RW] & addr_in_range(frm_addr_s, NUM_REGS);
          oe_d    = 1'b0;
          out_d   = 1'b0;
          state_d = IDLE;
        end else if (clk_rise_s) begin
          state_d = ERR;
        end else begin
          state_d = DONE;
        end
      end

      ERR: begin
        if (spenb_rise_s) begin
          ovr_d   = 1'b1;
          oe_d    = 1'b0;
          out_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = ERR;
        end
      end

      default: begin
        oe_d    = 1'b0;
        out_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Frame state, datapath and output registers
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      shift_q <= 16'h0000;
      rw_q    <= 1'b0;
      rdbuf_q <= 8'h00;
      rdval_q <= 8'h00;
      oe_q    <= 1'b0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      crw_q   <= 1'b0;
      caddr_q <= 7'h00;
      cdata_q <= 8'h00;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      arm_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      rw_q    <= rw_d;
      rdbuf_q <= rdbuf_d;
      rdval_q <= rdval_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      crw_q   <= crw_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      arm_q   <= arm_d;
    end
  end

  // Register file, written only on a committed in-range write frame
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= REG_RESET;
      end
    end else if (we_s) begin
      regs_q[waddr_s[IDX_W-1:0]] <= wdata_s;
    end
  end

  assign spda_out  = out_q;
  assign spda_oe   = oe_q;
  assign cmd_valid = valid_q;
  assign cmd_rw    = crw_q;
  assign cmd_addr  = caddr_q;
  assign cmd_data  = cdata_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_lcd_spi3w_slave.sv
// Self-checking bench for lcd_spi3w_slave: directed frames from the bring-up plan followed
// by randomized frames, all checked against a register-array reference model.
module tb_lcd_spi3w_slave;

  logic       sys_clk = 1'b0;
  logic       rst, spclk, spenb, spda_in;
  logic       spda_out, spda_oe, cmd_valid, cmd_rw, frame_err, overrun;
  logic [6:0] cmd_addr, rd_addr;
  logic [7:0] cmd_data, rd_data;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  int n_valid = 0, n_ferr = 0, n_ovr = 0;

  logic [7:0] model [16];
  logic [7:0] rx_byte;
  int         oe_hi_cnt, oe_early;

  always #10 sys_clk = ~sys_clk;

  lcd_spi3w_slave #(.SYNC_STAGES(2), .NUM_REGS(16), .REG_RESET(8'h00)) dut (
    .sys_clk  (sys_clk),
    .rst      (rst),
    .spclk    (spclk),
    .spenb    (spenb),
    .spda_in  (spda_in),
    .spda_out (spda_out),
    .spda_oe  (spda_oe),
    .cmd_valid(cmd_valid),
    .cmd_rw   (cmd_rw),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

  // Pulse counters: a pulse held too long counts more than once
  always @(posedge sys_clk) begin
    if (cmd_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_ferr++;
    if (overrun === 1'b1)   n_ovr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int r = 0; r < 16; r++) begin
      rd_addr = 7'(r);
      #1;
      chk($sformatf("%s reg%0d", tag, r), 32'(rd_data), 32'(model[r]));
    end
    rd_addr = 7'($urandom_range(16, 127));
    #1;
    chk($sformatf("%s rd_oor 0x%0h", tag, rd_addr), 32'(rd_data), 32'd0);
  endtask

  // Master side of one frame; rst_at >= 0 pulses reset just before that rising edge
  task automatic send_frame(input logic [15:0] f, input int nclk, input int rst_at);
    int half;
    half      = $urandom_range(6, 12);
    rx_byte   = 8'h00;
    oe_hi_cnt = 0;
    oe_early  = 0;
    @(negedge sys_clk);
    spenb = 1'b0;
    repeat (half) @(negedge sys_clk);
    for (int i = 0; i < nclk; i++) begin
      spda_in = (i < 16) ? f[15-i] : 1'($urandom_range(0, 1));
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
      end
      repeat (half) @(negedge sys_clk);
      if (i >= 8 && i < 16) begin
        rx_byte = {rx_byte[6:0], spda_out};
        if (spda_oe === 1'b1) oe_hi_cnt++;
      end else if (i < 8 && spda_oe !== 1'b0) begin
        oe_early++;
      end
      spclk = 1'b1;
      repeat (half) @(negedge sys_clk);
      spclk = 1'b0;
    end
    repeat (half) @(negedge sys_clk);
    spenb = 1'b1;
    repeat (12) @(negedge sys_clk);
  endtask

  task automatic run_frame(input string tag, input logic [15:0] f, input int nclk, input int rst_at);
    int         v0, e0, o0;
    logic [6:0] addr;
    logic       rw, inr;
    logic [7:0] exp_rd;
    v0     = n_valid;
    e0     = n_ferr;
    o0     = n_ovr;
    addr   = {f[15], f[13:8]};
    rw     = f[14];
    inr    = (addr < 7'd16);
    exp_rd = inr ? model[addr[3:0]] : 8'h00;
    send_frame(f, nclk, rst_at);
    if (rst_at >= 0) begin
      for (int r = 0; r < 16; r++) model[r] = 8'h00;
      chk({tag, " cmd_addr"}, 32'(cmd_addr), 32'd0);
      chk({tag, " cmd_data"}, 32'(cmd_data), 32'd0);
      chk({tag, " cmd_rw"}, 32'(cmd_rw), 32'd0);
    end else if (nclk == 16) begin
      chk({tag, " cmd_addr"}, 32'(cmd_addr), 32'(addr));
      chk({tag, " cmd_rw"}, 32'(cmd_rw), 32'(rw));
      chk({tag, " cmd_data"}, 32'(cmd_data), rw ? 32'(exp_rd) : 32'(f[7:0]));
      if (!rw && inr) model[addr[3:0]] = f[7:0];
      if (rw) begin
        chk({tag, " rx_byte"}, 32'(rx_byte), 32'(exp_rd));
        chk({tag, " oe_rises"}, 32'(oe_hi_cnt), 32'd8);
      end
    end
    chk({tag, " n_valid"}, 32'(n_valid - v0), (rst_at < 0 && nclk == 16) ? 32'd1 : 32'd0);
    chk({tag, " n_ferr"}, 32'(n_ferr - e0), (rst_at < 0 && nclk < 16) ? 32'd1 : 32'd0);
    chk({tag, " n_ovr"}, 32'(n_ovr - o0), (rst_at < 0 && nclk > 16) ? 32'd1 : 32'd0);
    chk({tag, " oe_early"}, 32'(oe_early), 32'd0);
    chk({tag, " oe_after"}, 32'(spda_oe), 32'd0);
    check_regs(tag);
  endtask

  initial begin
    int         sel, nclk;
    logic [15:0] f;
    rst     = 1'b1;
    spclk   = 1'b0;
    spenb   = 1'b1;
    spda_in = 1'b0;
    rd_addr = 7'd0;
    for (int r = 0; r < 16; r++) model[r] = 8'h00;
    repeat (4) @(negedge sys_clk);
    rst = 1'b0;
    repeat (6) @(negedge sys_clk);

    chk("rst cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst cmd_addr", 32'(cmd_addr), 32'd0);
    chk("rst cmd_data", 32'(cmd_data), 32'd0);
    chk("rst cmd_rw", 32'(cmd_rw), 32'd0);
    chk("rst spda_oe", 32'(spda_oe), 32'd0);
    chk("rst spda_out", 32'(spda_out), 32'd0);
    chk("rst frame_err", 32'(frame_err), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);
    check_regs("rst");

    run_frame("wr5", 16'h055F, 16, -1);
    run_frame("rd5", 16'h45A3, 16, -1);
    run_frame("short10", 16'h05AA, 10, -1);
    run_frame("after_short", 16'h0A3C, 16, -1);
    run_frame("over17", 16'h0577, 17, -1);
    run_frame("wr40", 16'h80C3, 16, -1);
    run_frame("rd40", 16'hC0FF, 16, -1);
    run_frame("rd_abort", 16'h4A00, 12, -1);
    run_frame("rst_mid", 16'h0599, 16, 6);
    run_frame("after_rst", 16'h0512, 16, -1);

    for (int k = 0; k < 16; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)      nclk = 16;
      else if (sel < 8) nclk = $urandom_range(1, 15);
      else              nclk = $urandom_range(17, 19);
      f = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0) f[15] = 1'b0;
      run_frame($sformatf("rnd%0d", k), f, nclk, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
